// File: rtl/fcs_mpc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fcs_mpc_sequencer
// Brief    : FCS-MPC loop sequencer: ADC handshake, shared-multiplier cost
//            evaluation, min-hold switch decision and period-overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module fcs_mpc_sequencer #(
  parameter int unsigned PERIOD   = 1000,
  parameter logic [31:0] K_IL     = 32'd7,
  parameter logic [31:0] K_VC     = 32'd7,
  parameter logic [31:0] K_VG     = 32'd1,
  parameter logic [39:0] OFFSET   = 40'd2560,
  parameter int unsigned MIN_HOLD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  output logic       adc_req,
  input  logic       adc_ack,
  input  logic [7:0] iL,
  input  logic [7:0] vc,
  input  logic [7:0] vg,
  output logic       u,
  output logic       u_valid,
  output logic       busy,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic       io_oeb
);

  localparam int unsigned c_cnt_w  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int unsigned c_hold_w = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(PERIOD - 1);
  localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(MIN_HOLD);
  localparam logic signed [41:0]  c_offset   = signed'({2'b00, OFFSET});

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_MUL_IL = 3'd2,
    S_MUL_VC = 3'd3,
    S_MUL_VG = 3'd4,
    S_DECIDE = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_hold_w-1:0] r_hold;
  logic [7:0]          r_il;
  logic [7:0]          r_vc;
  logic [7:0]          r_vg;
  logic signed [41:0]  r_acc;
  logic signed [41:0]  r_p;
  logic                r_adc_req;
  logic                r_u;
  logic                r_u_valid;
  logic                r_overrun;

  logic                w_tick;
  logic [7:0]          w_mul_a;
  logic [31:0]         w_mul_b;
  logic [39:0]         w_product;
  logic signed [41:0]  w_product_s;
  logic signed [41:0]  w_sum;
  logic signed [41:0]  w_abs_sum;
  logic signed [41:0]  w_abs_temp;
  logic                w_cand;

  // Period counter: held at zero while disabled so the first tick lands a full period after enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || (r_cnt == c_cnt_last)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick = enable && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (!enable) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_tick) w_next_state = S_REQ;
        S_REQ:    if (adc_ack) w_next_state = S_MUL_IL;
        S_MUL_IL: w_next_state = S_MUL_VC;
        S_MUL_VC: w_next_state = S_MUL_VG;
        S_MUL_VG: w_next_state = S_DECIDE;
        S_DECIDE: w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // Single shared 8x32 multiplier; operands are steered by the current MUL state.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_MUL_IL: begin w_mul_a = r_il; w_mul_b = K_IL; end
      S_MUL_VC: begin w_mul_a = r_vc; w_mul_b = K_VC; end
      S_MUL_VG: begin w_mul_a = r_vg; w_mul_b = K_VG; end
      default:  begin w_mul_a = '0;   w_mul_b = '0;   end
    endcase
  end

  assign w_product   = 40'(w_mul_a) * 40'(w_mul_b);
  assign w_product_s = signed'({2'b00, w_product});

  assign w_sum      = r_acc + r_p;
  assign w_abs_sum  = w_sum[41] ? -w_sum : w_sum;
  assign w_abs_temp = r_acc[41] ? -r_acc : r_acc;
  assign w_cand     = (w_abs_sum <= w_abs_temp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_il  <= '0;
      r_vc  <= '0;
      r_vg  <= '0;
      r_acc <= '0;
      r_p   <= '0;
    end else begin
      if ((r_state == S_REQ) && adc_ack) begin
        r_il <= iL;
        r_vc <= vc;
        r_vg <= vg;
      end
      case (r_state)
        S_MUL_IL: r_acc <= w_product_s - c_offset;
        S_MUL_VC: r_acc <= r_acc + w_product_s;
        S_MUL_VG: r_p   <= w_product_s;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adc_req <= 1'b0;
      r_u       <= 1'b0;
      r_u_valid <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_adc_req <= (w_next_state == S_REQ);
      r_u_valid <= 1'b0;
      if (!enable) begin
        // Abort leaves the hold satisfied so the first decision after re-enable applies at once.
        r_u    <= 1'b0;
        r_hold <= c_hold_max;
      end else if (r_state == S_DECIDE) begin
        r_u_valid <= 1'b1;
        if ((w_cand != r_u) && (r_hold >= c_hold_max)) begin
          r_u    <= w_cand;
          r_hold <= '0;
        end else if (r_hold < c_hold_max) begin
          r_hold <= r_hold + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_tick && (r_state != S_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

  assign adc_req = r_adc_req;
  assign u       = r_u;
  assign u_valid = r_u_valid;
  assign busy    = (r_state != S_IDLE);
  assign overrun = r_overrun;
  assign io_oeb  = 1'b0;

endmodule
`default_nettype wire

// File: doc/fcs_mpc_sequencer.md
Name: fcs_mpc_sequencer

Overview:
- Clocked sequencer around the finite-control-set MPC cost evaluation for the converter switch.
- Every control period it requests one ADC sample set (iL, vc, vg) over a req/ack handshake.
- It evaluates both candidate switch states' costs on a single shared multiplier over several cycles, then registers the switch command u.
- It enforces a minimum hold on switch changes and flags control-period overruns.

Parameters:
- PERIOD, 1000, control period in clk cycles (>= 16).
- K_IL, 7, unsigned 32-bit iL coefficient.
- K_VC, 7, unsigned 32-bit vc coefficient.
- K_VG, 1, unsigned 32-bit vg coefficient.
- OFFSET, 2560, unsigned 40-bit reference offset.
- MIN_HOLD, 2, minimum number of decisions u must remain unchanged after any toggle (0 = no hold).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run control loop.
- adc_req  out  1  sample request.
- adc_ack  in  1  sample valid; iL/vc/vg captured on the cycle it is high while adc_req=1.
- iL  in  8  unsigned inductor current sample.
- vc  in  8  unsigned capacitor voltage sample.
- vg  in  8  unsigned input voltage sample.
- u  out  1  registered switch command.
- u_valid  out  1  one-cycle pulse when u is (re)decided.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky period-overrun flag.
- clr_overrun  in  1  clears overrun.
- io_oeb  out  1  constant 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, period counter=0, u=0, u_valid=0, adc_req=0, overrun=0, hold counter=0, accumulator=0, sample registers=0. io_oeb=0 always.
- Period counter: runs only while enable=1. Counts 0..PERIOD-1 and wraps. tick is asserted on the cycle the count equals PERIOD-1.
- FSM states: IDLE, REQ, MUL_IL, MUL_VC, MUL_VG, DECIDE.
- IDLE -> REQ on tick. adc_req is a registered output, high from the cycle after the tick.
- REQ: adc_req stays high until adc_ack=1. On the ack cycle, latch iL/vc/vg and drop adc_req the next cycle. Then go to MUL_IL. No timeout.
- MUL_IL: acc = K_IL*iL - OFFSET.
- MUL_VC: acc += K_VC*vc. The accumulator value is now temp.
- MUL_VG: p = K_VG*vg.
- DECIDE: cand = (|temp + p| <= |temp|). Ties select 1.
- One multiplier instance (8x32 -> 40-bit unsigned) is shared by all MUL states.
- Arithmetic is 42-bit two's-complement signed, with operands zero-extended. abs() is taken on the 42-bit value. No saturation is needed; the widths cannot overflow.
- Latency: ack at cycle A -> MUL_IL at A+1, MUL_VC A+2, MUL_VG A+3, DECIDE A+4. u updates and u_valid=1 at A+5, then the FSM is in IDLE.
- Min hold:
  - The hold counter counts decisions since the last toggle and saturates at MIN_HOLD.
  - If cand != u and hold counter < MIN_HOLD: u is kept, hold counter increments, u_valid still pulses.
  - If u toggles: hold counter resets to 0.
- Overrun: a tick arriving while busy=1 sets overrun and is dropped; the in-flight cycle continues.
  - clr_overrun clears overrun unless a new overrun occurs in the same cycle; set wins.
- enable=0:
  - Synchronous abort. Next cycle: FSM=IDLE, adc_req=0, period counter=0, u=0, hold counter=MIN_HOLD, u_valid=0.
  - overrun is retained.
  - After re-enable, the first tick occurs PERIOD cycles later.
- adc_ack while not in REQ is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-REQ -> adc_req, u, u_valid, overrun are 0 immediately (async); first adc_req appears exactly PERIOD cycles after release with enable=1.
- Decision u=1: iL=100, vc=200, vg=50 (temp=-460, cost1=410) -> u=1, with u_valid exactly 5 cycles after the ack cycle.
- Decision u=0 with hold: start u=1 with hold satisfied; iL=200, vc=200, vg=50 (temp=240, cost1=290) -> u=0. With MIN_HOLD=2, the next two decisions demanding u=1 keep u=0; the third toggles u to 1.
- Tie: iL=165, vc=200, vg=10 (temp=-5, cost1=5) -> u=1.
- Overrun: PERIOD=16, withhold adc_ack for 20 cycles -> overrun=1 and the late tick is dropped; pulse clr_overrun -> overrun=0. Then assert clr_overrun on the same cycle as a new overrun -> overrun stays 1.
- Enable abort: drop enable during MUL_VC -> next cycle busy=0, u=0, no u_valid. Re-enable -> normal decision one period later, applied without hold delay.
